// File: rtl/epb_txc_xfer.sv
// epb_txc_xfer: credit-controlled, packet-locked round-robin segment transfer from EPB channels to TXC.
// Define EPB_TXC_XFER_CRD_CHK_EN for the sticky credit-overflow flags and the protocol assertions.
module epb_txc_xfer #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 256,
  parameter int CRD_MAX = 8,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int CRD_W   = $clog2(CRD_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        epb_vld,
  input  logic [NUM_CH-1:0]        epb_sop,
  input  logic [NUM_CH-1:0]        epb_eop,
  input  logic [NUM_CH*DATA_W-1:0] epb_data,
  output logic [NUM_CH-1:0]        epb_rdy,
  output logic                     txc_vld,
  output logic [CH_W-1:0]          txc_ch,
  output logic                     txc_sop,
  output logic                     txc_eop,
  output logic [DATA_W-1:0]        txc_data,
  input  logic [NUM_CH-1:0]        txc_crd_rtn,
  output logic [NUM_CH*CRD_W-1:0]  crd_avail,
  output logic [NUM_CH-1:0]        crd_ovf_err
);
  typedef enum logic {IDLE, LOCK} state_t;
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CRD_MAX);
  state_t            state_q, state_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d, ptr_q, ptr_d, idx, gnt_ch;
  logic [CRD_W-1:0]  crd_q [NUM_CH];
  logic [CRD_W-1:0]  crd_d [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic              gnt;
  logic              vld_q, sop_q, eop_q;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++)
      elig[c] = epb_vld[c] && (crd_q[c] != '0) &&
                ((state_q == IDLE) ? epb_sop[c] : (lock_ch_q == CH_W'(c)));
  end
  // Search starts one past the last sop winner; in LOCK only lock_ch can be eligible.
  always_comb begin
    gnt = 1'b0;
    gnt_ch = '0;
    idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!gnt && elig[idx]) begin
        gnt = 1'b1;
        gnt_ch = idx;
      end
    end
    epb_rdy = gnt ? (NUM_CH'(1) << gnt_ch) : '0;
  end
  always_comb begin
    state_d = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d = ptr_q;
    if (gnt) begin
      state_d = epb_eop[gnt_ch] ? IDLE : LOCK;
      lock_ch_d = gnt_ch;
      ptr_d = epb_sop[gnt_ch] ? gnt_ch : ptr_q;
    end
  end
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      crd_d[c] = (txc_crd_rtn[c] && !epb_rdy[c]) ? ((crd_q[c] == CRD_FULL) ? crd_q[c] : crd_q[c] + CRD_W'(1)) :
                 (epb_rdy[c] && !txc_crd_rtn[c]) ? crd_q[c] - CRD_W'(1) : crd_q[c];
  end
  assign ch_d   = gnt ? gnt_ch : ch_q;
  assign data_d = gnt ? epb_data[gnt_ch*DATA_W +: DATA_W] : data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      ptr_q     <= '0;
      crd_q     <= '{default: CRD_FULL};
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      ch_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      crd_q     <= crd_d;
      vld_q     <= gnt;
      sop_q     <= gnt && epb_sop[gnt_ch];
      eop_q     <= gnt && epb_eop[gnt_ch];
      ch_q      <= ch_d;
      data_q    <= data_d;
    end
  end
  assign txc_vld  = vld_q;
  assign txc_ch   = ch_q;
  assign txc_sop  = sop_q;
  assign txc_eop  = eop_q;
  assign txc_data = data_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_crd
    assign crd_avail[g*CRD_W +: CRD_W] = crd_q[g];
  end
`ifdef EPB_TXC_XFER_CRD_CHK_EN
  logic [NUM_CH-1:0] ovf_q, ovf_d, crd_zero;
  always_comb begin
    ovf_d = ovf_q;
    crd_zero = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      crd_zero[c] = (crd_q[c] == '0);
      ovf_d[c] = ovf_q[c] | (txc_crd_rtn[c] && !epb_rdy[c] && (crd_q[c] == CRD_FULL));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end
  assign crd_ovf_err = ovf_q;
  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(epb_rdy));
  a_idle_sop:   assert property (@(posedge clk) disable iff (!rst_n) !(state_q == IDLE && |(epb_rdy & ~epb_sop)));
  a_zero_crd:   assert property (@(posedge clk) disable iff (!rst_n) !(|(epb_rdy & crd_zero)));
`else
  assign crd_ovf_err = '0;
`endif
endmodule
